pwm_multi_ch: RTL and testbench

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

---
 rtl/pwm_multi_ch.sv | 133 +++++++++++++
 tb/tb_pwm_multi_ch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi_ch
// Purpose  : Multi-channel PWM generator with a shared counter. It supports
//            edge-aligned and center-aligned modes. Each channel's duty value
//            is double-buffered (shadow -> active). Active settings only change
//            at a period boundary, so a period never mixes settings.
// Ports    : clk          - clock, all state on rising edge
//            resetn       - asynchronous active-low reset
//            en           - 1 = run, 0 = counter held at 0, outputs low
//            mode         - 0 = edge-aligned, 1 = center-aligned
//            period       - requested period P (applied at boundary)
//            wr_en        - duty write strobe
//            wr_ch        - channel index for the write (out-of-range ignored)
//            wr_duty      - duty value for the write
//            pwm_out      - registered PWM outputs, one per channel
//            cycle_start  - registered one-cycle pulse at period start
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi_ch #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                cycle_start
);

    localparam logic [CH_W:0]    c_channels = (CH_W+1)'(CHANNELS);
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    logic [WIDTH-1:0]    r_cnt;
    logic                r_down;
    logic [WIDTH-1:0]    r_period_act;
    logic                r_mode_act;
    logic [WIDTH-1:0]    r_shadow   [CHANNELS];
    logic [WIDTH-1:0]    r_duty_act [CHANNELS];

    logic                w_run;
    logic                w_last;
    logic                w_wr_ok;
    logic                w_load;
    logic [WIDTH-1:0]    w_cnt_nxt;
    logic                w_down_nxt;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_cmp;

    // A zero active period behaves like a disabled block: the counter is held
    // and nothing toggles.
    assign w_run   = en && (r_period_act != '0);
    assign w_last  = (r_cnt == (r_period_act - c_one));
    assign w_wr_ok = wr_en && ({1'b0, wr_ch} < c_channels);

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            assign w_hit[g] = w_wr_ok && (wr_ch == CH_W'(g));
            assign w_cmp[g] = (r_cnt < r_duty_act[g]);
        end
    endgenerate

    // Counter sequencing. In center mode the end values are each visited
    // twice (P-1 at the top, 0 at the bottom). This gives a 2P-cycle period.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_down_nxt = r_down;
        if (!w_run) begin
            w_cnt_nxt  = '0;
            w_down_nxt = 1'b0;
        end else if (!r_mode_act) begin
            w_cnt_nxt  = w_last ? '0 : (r_cnt + c_one);
        end else if (!r_down) begin
            if (w_last) begin
                w_down_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_one;
            end
        end else begin
            if (r_cnt == '0) begin
                w_down_nxt = 1'b0;
            end else begin
                w_cnt_nxt = r_cnt - c_one;
            end
        end
    end

    // The boundary is the edge that puts the counter at 0 in the up phase.
    // While idle, every edge counts as a boundary. This lets new settings land
    // before the first period.
    assign w_load = !w_run || ((w_cnt_nxt == '0) && !w_down_nxt);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_down       <= 1'b0;
            r_period_act <= '0;
            r_mode_act   <= 1'b0;
            pwm_out      <= '0;
            cycle_start  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i]   <= '0;
                r_duty_act[i] <= '0;
            end
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_down      <= w_down_nxt;
            pwm_out     <= w_run ? w_cmp : '0;
            cycle_start <= w_run && (r_cnt == '0) && !r_down;
            if (w_load) begin
                r_period_act <= period;
                r_mode_act   <= mode;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_hit[i]) begin
                    r_shadow[i] <= wr_duty;
                end
                // A write that coincides with the boundary goes straight through.
                if (w_load) begin
                    r_duty_act[i] <= w_hit[i] ? wr_duty : r_shadow[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi_ch
// Purpose  : Scoreboard bench for pwm_multi_ch. The stimulus pushes
//            cycle-stamped expected outputs into a queue. A monitor pops and
//            compares them on every falling edge. A 4-channel and a 3-channel
//            instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_ch;

    localparam logic [15:0] c_d0  = 16'h0000;
    localparam logic [15:0] c_d2  = 16'h0003;
    localparam logic [15:0] c_d3  = 16'h0007;
    localparam logic [15:0] c_d5  = 16'h001F;
    localparam logic [15:0] c_d6  = 16'h003F;
    localparam logic [15:0] c_d7  = 16'h007F;
    localparam logic [15:0] c_f10 = 16'h03FF;
    localparam logic [15:0] c_c2  = 16'hC003;
    localparam logic [15:0] c_all = 16'hFFFF;

    logic       clk;
    logic       resetn;
    logic       en;
    logic       mode;
    logic [7:0] period;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] pwm4;
    logic       cs4;
    logic [2:0] pwm3;
    logic       cs3;

    pwm_multi_ch #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .en(en), .mode(mode), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm4), .cycle_start(cs4)
    );

    pwm_multi_ch #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .en(en), .mode(mode), .period(period),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm3), .cycle_start(cs3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [3:0] e4;
        logic [2:0] e3;
        logic       cs;
        logic       cs_care;
    } exp_t;

    exp_t  sb[$];
    string sb_nm[$];
    int    total = 0;
    int    bad   = 0;

    task automatic push(input int c, input logic [3:0] e4, input logic cs,
                        input logic care, input string nm);
        exp_t e;
        e.cyc = c; e.e4 = e4; e.e3 = e4[2:0]; e.cs = cs; e.cs_care = care;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    task automatic push_zeros(input int c0, input int c1, input logic care, input string nm);
        for (int c = c0; c <= c1; c++) push(c, 4'b0000, 1'b0, care, nm);
    endtask

    // Bit j of each pattern is the channel level at phase j of the period.
    task automatic exp_per(input int t, input int nper, input int plen,
                           input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3,
                           input string nm);
        for (int k = 0; k < nper; k++) begin
            for (int j = 0; j < plen; j++) begin
                push(t + k*plen + j, {p3[j], p2[j], p1[j], p0[j]}, (j == 0), 1'b1, nm);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            total++;
            bad++;
            $display("FAIL %s: cycle %0d expectation never compared (now cycle %0d)", nm, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            total++;
            if (pwm4 !== e.e4 || pwm3 !== e.e3 ||
                (e.cs_care && (cs4 !== e.cs || cs3 !== e.cs))) begin
                bad++;
                $display("FAIL %s: cycle %0d got pwm4=%b pwm3=%b cs4=%b cs3=%b, want pwm4=%b pwm3=%b cs=%b (care=%b)",
                         nm, cyc, pwm4, pwm3, cs4, cs3, e.e4, e.e3, e.cs, e.cs_care);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_duty = d;
        tick();
        wr_en = 1'b0;
    endtask

    int t0, u, v, w;

    initial begin
        resetn = 1'b0; en = 1'b0; mode = 1'b0; period = 8'd10;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0;

        // Reset state, then idle with en=0.
        push_zeros(1, 5, 1'b1, "reset_idle");
        wait_cyc(3);
        resetn = 1'b1;
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd7);

        // Edge mode, P=10. First cycle_start comes one cycle after en rises.
        en = 1'b1;
        t0 = cyc + 1;
        exp_per(t0,      4, 10, c_d3, c_d7, c_d0, c_d0, "edge_3_7");
        exp_per(t0 + 40, 1, 10, c_d6, c_d7, c_d0, c_d0, "late_write");
        exp_per(t0 + 50, 1, 10, c_d2, c_d7, c_d0, c_d0, "boundary_write");
        exp_per(t0 + 60, 1, 10, c_d2, c_d7, c_d0, c_d0, "pre_const");
        exp_per(t0 + 70, 3, 10, c_d2, c_d0, c_f10, c_f10, "const_0_10_255");
        exp_per(t0 + 100, 1, 10, c_d2, c_d0, c_f10, c_f10, "period0_pending");
        push_zeros(t0 + 110, t0 + 131, 1'b1, "period0");

        wait_cyc(t0 + 33);            // counter is at 4 here
        wr(2'd0, 8'd6);
        wait_cyc(t0 + 48);            // counter is at 9: boundary on next edge
        wr(2'd0, 8'd2);
        wait_cyc(t0 + 61);
        wr(2'd1, 8'd0);
        wr(2'd2, 8'd10);
        wr(2'd3, 8'd255);             // out of range for the 3-channel instance
        wait_cyc(t0 + 100);
        period = 8'd0;

        // Center mode, P=8, loaded while disabled.
        u = t0 + 130;
        exp_per(u + 2, 3, 16, c_c2, c_d0, c_all, c_all, "center_p8");
        push(u + 50, 4'b1101, 1'b1, 1'b1, "center_last");
        push_zeros(u + 51, u + 53, 1'b1, "en_drop");
        wait_cyc(u);
        en = 1'b0; mode = 1'b1; period = 8'd8;
        wait_cyc(u + 1);
        en = 1'b1;
        wait_cyc(u + 50);
        en = 1'b0;

        // Back to edge mode, then an asynchronous reset mid-pulse.
        v = u + 53;
        w = v + 41;
        push(v + 1, 4'b0000, 1'b0, 1'b1, "restart");
        exp_per(v + 2, 1, 10, c_d2, c_d0, c_f10, c_f10, "edge_again");
        push_zeros(v + 12, v + 14, 1'b1, "async_reset");
        push_zeros(v + 15, w, 1'b0, "post_reset_low");
        push(w + 1, 4'b0000, 1'b0, 1'b1, "rewrite_idle");
        exp_per(w + 2, 2, 10, c_d0, c_d5, c_d0, c_d0, "post_reset_d5");
        wait_cyc(v);
        mode = 1'b0; period = 8'd10;
        wait_cyc(v + 1);
        en = 1'b1;
        wait_cyc(v + 12);
        #2;
        resetn = 1'b0;
        wait_cyc(v + 15);
        resetn = 1'b1;
        wait_cyc(w);
        en = 1'b0;
        wr(2'd1, 8'd5);
        en = 1'b1;
        wait_cyc(w + 23);

        if (sb.size() != 0) begin
            total += sb.size();
            bad   += sb.size();
            $display("FAIL leftover: %0d expectations never compared, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
